line_buffer: RTL and testbench

Upstream stage of the terminal auto-update/autocomplete path. Accepts a byte stream from the UART receiver with a valid/ready handshake and edits it into a zero-filled line buffer, handling backspace and line termination. Exposes an asynchronous random-access read port indexed by the downstream command matcher's 5-bit address, where unwritten positions read as 8'd0. Flags a completed line until the consumer acknowledges it.

---
 rtl/linebuf_pkg.sv | 16 +
 rtl/linebuf_mem.sv | 24 ++
 rtl/line_buffer.sv | 160 ++++++++++++++++
 tb/tb_line_buffer.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/linebuf_pkg.sv
// Shared types and character constants for the line buffer.
package linebuf_pkg;

    typedef enum logic [1:0] {
        S_CLEAR = 2'd0,
        S_FILL  = 2'd1,
        S_READY = 2'd2
    } state_e;

    localparam logic [7:0] ASCII_CR  = 8'd13;
    localparam logic [7:0] ASCII_LF  = 8'd10;
    localparam logic [7:0] ASCII_BS  = 8'd8;
    localparam logic [7:0] ASCII_DEL = 8'd127;
    localparam logic [7:0] ASCII_NUL = 8'd0;

endpackage

// File: rtl/linebuf_mem.sv
// Line storage: DEPTH x 8, one synchronous write port, one asynchronous read port.
module linebuf_mem #(
    parameter int unsigned DEPTH  = 32,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [7:0]        wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [7:0]        rdata_o
);

    logic [7:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/line_buffer.sv
// Edits a received byte stream into a zero-filled line buffer with backspace and termination.
// Optional echo output is enabled by defining LINEBUF_ECHO_EN.
module line_buffer
    import linebuf_pkg::*;
#(
    parameter int unsigned DEPTH  = 32,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [7:0]        rx_data_i,
    input  logic              rx_valid_i,
    output logic              rx_ready_o,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [7:0]        rd_data_o,
    output logic [ADDR_W:0]   line_len_o,
    output logic              line_ready_o,
    input  logic              line_ack_i,
    output logic              overflow_o,
    output logic [7:0]        echo_data_o,
    output logic              echo_valid_o
);

    localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(DEPTH - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic              overflow_q, overflow_d;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;

    always_comb begin
        state_d      = state_q;
        clr_cnt_d    = clr_cnt_q;
        wr_ptr_d     = wr_ptr_q;
        overflow_d   = overflow_q;
        mem_we       = 1'b0;
        mem_waddr    = clr_cnt_q;
        mem_wdata    = ASCII_NUL;
        rx_ready_o   = 1'b0;
        line_ready_o = 1'b0;

        unique case (state_q)
            S_CLEAR: begin
                mem_we    = 1'b1;
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == LastIdx) begin
                    state_d   = S_FILL;
                    wr_ptr_d  = '0;
                    clr_cnt_d = '0;
                end
            end
            S_FILL: begin
                rx_ready_o = 1'b1;
                if (rx_valid_i) begin
                    if (rx_data_i == ASCII_CR || rx_data_i == ASCII_LF) begin
                        state_d = S_READY;
                    end else if (rx_data_i == ASCII_BS || rx_data_i == ASCII_DEL) begin
                        if (wr_ptr_q != '0) begin
                            wr_ptr_d  = wr_ptr_q - 1'b1;
                            mem_we    = 1'b1;
                            mem_waddr = wr_ptr_q - 1'b1;
                        end
                    end else if (rx_data_i != ASCII_NUL) begin
                        // Last entry is reserved as the terminating zero.
                        if (wr_ptr_q < LastIdx) begin
                            wr_ptr_d  = wr_ptr_q + 1'b1;
                            mem_we    = 1'b1;
                            mem_waddr = wr_ptr_q;
                            mem_wdata = rx_data_i;
                        end else begin
                            overflow_d = 1'b1;
                        end
                    end
                end
            end
            S_READY: begin
                line_ready_o = 1'b1;
                if (line_ack_i) begin
                    state_d    = S_CLEAR;
                    clr_cnt_d  = '0;
                    overflow_d = 1'b0;
                end
            end
            default: state_d = S_CLEAR;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_CLEAR;
            clr_cnt_q  <= '0;
            wr_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_cnt_q  <= clr_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            overflow_q <= overflow_d;
        end
    end

    linebuf_mem #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk_i   (clk_i),
        .we_i    (mem_we),
        .waddr_i (mem_waddr),
        .wdata_i (mem_wdata),
        .raddr_i (rd_addr_i),
        .rdata_o (mem_rdata)
    );

    // Contents are stale until the clear pass completes.
    assign rd_data_o  = (state_q == S_CLEAR) ? 8'd0 : mem_rdata;
    assign line_len_o = {1'b0, wr_ptr_q};
    assign overflow_o = overflow_q;

`ifdef LINEBUF_ECHO_EN
    logic       echo_valid_d, echo_valid_q;
    logic [7:0] echo_data_d, echo_data_q;

    // Any buffer write in S_FILL is an edit; a zero write can only be a backspace.
    always_comb begin
        echo_valid_d = (state_q == S_FILL) && (mem_we || (state_d == S_READY));
        echo_data_d  = echo_data_q;
        if (echo_valid_d) begin
            if (state_d == S_READY) begin
                echo_data_d = ASCII_CR;
            end else if (mem_wdata == ASCII_NUL) begin
                echo_data_d = ASCII_BS;
            end else begin
                echo_data_d = mem_wdata;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            echo_valid_q <= 1'b0;
            echo_data_q  <= 8'd0;
        end else begin
            echo_valid_q <= echo_valid_d;
            echo_data_q  <= echo_data_d;
        end
    end

    assign echo_valid_o = echo_valid_q;
    assign echo_data_o  = echo_data_q;
`else
    assign echo_valid_o = 1'b0;
    assign echo_data_o  = 8'd0;
`endif

endmodule

// File: tb/tb_line_buffer.sv
// Self-checking bench for line_buffer against a queue-based model of the edited line.
module tb_line_buffer;

    localparam int DEPTH  = 32;
    localparam int ADDR_W = 5;
`ifdef LINEBUF_ECHO_EN
    localparam bit ECHO = 1'b1;
`else
    localparam bit ECHO = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [7:0]        rx_data = 8'd0;
    logic              rx_valid = 1'b0;
    logic              rx_ready;
    logic [ADDR_W-1:0] rd_addr = '0;
    logic [7:0]        rd_data;
    logic [ADDR_W:0]   line_len;
    logic              line_ready;
    logic              line_ack = 1'b0;
    logic              overflow;
    logic [7:0]        echo_data;
    logic              echo_valid;

    int checks = 0;
    int errors = 0;

    byte unsigned line_q[$];
    bit           m_ovf = 1'b0;

    always #5 clk = ~clk;

    line_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .rx_data_i    (rx_data),
        .rx_valid_i   (rx_valid),
        .rx_ready_o   (rx_ready),
        .rd_addr_i    (rd_addr),
        .rd_data_o    (rd_data),
        .line_len_o   (line_len),
        .line_ready_o (line_ready),
        .line_ack_i   (line_ack),
        .overflow_o   (overflow),
        .echo_data_o  (echo_data),
        .echo_valid_o (echo_valid)
    );

    // Reference: the line is the list of kept characters; everything past it reads 0.
    task automatic model_step(input logic [7:0] b, output bit ev, output logic [7:0] ed);
        ev = 1'b0;
        ed = 8'd0;
        if (b == 8'd13 || b == 8'd10) begin
            ev = 1'b1; ed = 8'd13;
        end else if (b == 8'd8 || b == 8'd127) begin
            if (line_q.size() > 0) begin
                void'(line_q.pop_back());
                ev = 1'b1; ed = 8'd8;
            end
        end else if (b != 8'd0) begin
            if (line_q.size() < DEPTH - 1) begin
                line_q.push_back(b);
                ev = 1'b1; ed = b;
            end else begin
                m_ovf = 1'b1;
            end
        end
        if (!ECHO) begin
            ev = 1'b0; ed = 8'd0;
        end
    endtask

    function automatic logic [7:0] exp_mem(input int i);
        return (i < line_q.size()) ? line_q[i] : 8'd0;
    endfunction

    task automatic drive_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk);
        #1;
    endtask

    task automatic end_drive();
        rx_valid = 1'b0;
        rx_data  = 8'd0;
    endtask

    task automatic do_ack();
        line_ack = 1'b1;
        @(posedge clk);
        #1;
        line_ack = 1'b0;
        line_q.delete();
        m_ovf = 1'b0;
    endtask

    task automatic wait_clear(output int n);
        n = 0;
        while (rx_ready !== 1'b1 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic test_reset();
        int n;
        rst = 1'b1;
        rd_addr = ADDR_W'($urandom_range(0, DEPTH - 1));
        repeat (2) @(posedge clk);
        #1;
        checks++; if (rx_ready !== 1'b0) begin errors++; $display("FAIL reset_rx_ready got %b want 0", rx_ready); end
        checks++; if (line_ready !== 1'b0) begin errors++; $display("FAIL reset_line_ready got %b want 0", line_ready); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b want 0", overflow); end
        checks++; if (line_len !== 6'd0) begin errors++; $display("FAIL reset_line_len got %0d want 0", line_len); end
        checks++; if (echo_valid !== 1'b0 || echo_data !== 8'd0) begin
            errors++; $display("FAIL reset_echo got %b/%0d want 0/0", echo_valid, echo_data);
        end
        checks++; if (rd_data !== 8'd0) begin errors++; $display("FAIL reset_rd_data got %0d want 0", rd_data); end
        rst = 1'b0;
        wait_clear(n);
        checks++; if (n != DEPTH) begin errors++; $display("FAIL reset_clear_len got %0d want %0d", n, DEPTH); end
        for (int i = 0; i < DEPTH; i++) begin
            rd_addr = ADDR_W'(i);
            @(negedge clk);
            checks++; if (rd_data !== 8'd0) begin errors++; $display("FAIL reset_mem[%0d] got %0d want 0", i, rd_data); end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_uname();
        string s = "uname -a";
        bit ev;
        logic [7:0] ed;
        int n;
        for (int i = 0; i < s.len(); i++) begin
            model_step(s[i], ev, ed);
            drive_byte(s[i]);
        end
        model_step(8'd13, ev, ed);
        drive_byte(8'd13);
        end_drive();
        checks++; if (line_ready !== 1'b1 || rx_ready !== 1'b0) begin
            errors++; $display("FAIL uname_term got ready=%b rx_ready=%b want 1/0", line_ready, rx_ready);
        end
        checks++; if (line_len !== 6'd8) begin errors++; $display("FAIL uname_len got %0d want 8", line_len); end
        for (int i = 0; i < DEPTH; i++) begin
            rd_addr = ADDR_W'(i);
            @(negedge clk);
            checks++; if (rd_data !== exp_mem(i)) begin
                errors++; $display("FAIL uname_mem[%0d] got %0d want %0d", i, rd_data, exp_mem(i));
            end
        end
        @(posedge clk); #1;
        do_ack();
        checks++; if (line_ready !== 1'b0 || rx_ready !== 1'b0) begin
            errors++; $display("FAIL uname_ack got ready=%b rx_ready=%b want 0/0", line_ready, rx_ready);
        end
        wait_clear(n);
        checks++; if (n != DEPTH) begin errors++; $display("FAIL uname_clear_len got %0d want %0d", n, DEPTH); end
    endtask

    task automatic test_echo_build();
        logic [7:0] seq [8] = '{8'd99, 8'd108, 8'd120, 8'd8, 8'd101, 8'd97, 8'd114, 8'd13};
        bit ev;
        logic [7:0] ed;
        int n;
        for (int i = 0; i < 8; i++) begin
            model_step(seq[i], ev, ed);
            drive_byte(seq[i]);
            checks++; if (echo_valid !== ev || ((ev || !ECHO) && echo_data !== ed)) begin
                errors++; $display("FAIL echo_build[%0d] got %b/%0d want %b/%0d", i, echo_valid, echo_data, ev, ed);
            end
        end
        end_drive();
        checks++; if (line_len !== 6'd5 || line_ready !== 1'b1) begin
            errors++; $display("FAIL clear_len got %0d/%b want 5/1", line_len, line_ready);
        end
        for (int i = 0; i < DEPTH; i++) begin
            rd_addr = ADDR_W'(i);
            @(negedge clk);
            checks++; if (rd_data !== exp_mem(i)) begin
                errors++; $display("FAIL clear_mem[%0d] got %0d want %0d", i, rd_data, exp_mem(i));
            end
        end
        @(posedge clk); #1;
        do_ack();
        wait_clear(n);
    endtask

    task automatic test_overflow();
        logic [7:0] tail [4] = '{8'd8, 8'd98, 8'd99, 8'd13};
        bit ev;
        logic [7:0] ed;
        int n;
        for (int i = 0; i < 40; i++) begin
            model_step(8'd97, ev, ed);
            drive_byte(8'd97);
        end
        checks++; if (line_len !== 6'd31 || overflow !== 1'b1) begin
            errors++; $display("FAIL ovf_full got len=%0d ovf=%b want 31/1", line_len, overflow);
        end
        for (int i = 0; i < 4; i++) begin
            model_step(tail[i], ev, ed);
            drive_byte(tail[i]);
            checks++; if (line_len !== 6'(line_q.size()) || overflow !== m_ovf) begin
                errors++; $display("FAIL ovf_tail[%0d] got len=%0d ovf=%b want %0d/%b",
                                   i, line_len, overflow, line_q.size(), m_ovf);
            end
        end
        end_drive();
        checks++; if (line_ready !== 1'b1) begin errors++; $display("FAIL ovf_term got %b want 1", line_ready); end
        for (int i = 0; i < DEPTH; i++) begin
            rd_addr = ADDR_W'(i);
            @(negedge clk);
            checks++; if (rd_data !== exp_mem(i)) begin
                errors++; $display("FAIL ovf_mem[%0d] got %0d want %0d", i, rd_data, exp_mem(i));
            end
        end
        @(posedge clk); #1;
        do_ack();
        wait_clear(n);
        checks++; if (overflow !== 1'b0 || n != DEPTH) begin
            errors++; $display("FAIL ovf_clear got ovf=%b cycles=%0d want 0/%0d", overflow, n, DEPTH);
        end
    endtask

    task automatic test_ignored();
        logic [7:0] seq [3] = '{8'd8, 8'd0, 8'd127};
        bit ev;
        logic [7:0] ed;
        int n;
        for (int i = 0; i < 3; i++) begin
            model_step(seq[i], ev, ed);
            drive_byte(seq[i]);
            checks++; if (line_len !== 6'd0 || echo_valid !== 1'b0) begin
                errors++; $display("FAIL ignored[%0d] got len=%0d echo=%b want 0/0", i, line_len, echo_valid);
            end
        end
        end_drive();
        line_ack = 1'b1;
        @(posedge clk); #1;
        line_ack = 1'b0;
        checks++; if (rx_ready !== 1'b1 || line_ready !== 1'b0) begin
            errors++; $display("FAIL ack_in_fill got rx_ready=%b ready=%b want 1/0", rx_ready, line_ready);
        end
        model_step(8'd13, ev, ed);
        drive_byte(8'd13);
        rx_data = 8'd122;
        repeat (5) @(posedge clk);
        #1;
        checks++; if (line_len !== 6'd0 || line_ready !== 1'b1) begin
            errors++; $display("FAIL hold_ready got len=%0d ready=%b want 0/1", line_len, line_ready);
        end
        do_ack();
        wait_clear(n);
        end_drive();
        checks++; if (n != DEPTH || line_len !== 6'd0) begin
            errors++; $display("FAIL hold_clear got cycles=%0d len=%0d want %0d/0", n, line_len, DEPTH);
        end
        rd_addr = '0;
        @(negedge clk);
        checks++; if (rd_data !== 8'd0) begin errors++; $display("FAIL hold_mem0 got %0d want 0", rd_data); end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        bit ev;
        logic [7:0] ed;
        logic [7:0] b;
        int n;
        for (int line = 0; line < 6; line++) begin
            int len = $urandom_range(0, 45);
            for (int k = 0; k < len; k++) begin
                int r = $urandom_range(0, 99);
                if (r < 12) b = (r < 6) ? 8'd8 : 8'd127;
                else if (r < 15) b = 8'd0;
                else begin
                    b = 8'($urandom_range(1, 255));
                    while (b == 8'd8 || b == 8'd10 || b == 8'd13 || b == 8'd127) b = 8'($urandom_range(1, 255));
                end
                model_step(b, ev, ed);
                drive_byte(b);
                checks++; if (line_len !== 6'(line_q.size()) || overflow !== m_ovf || echo_valid !== ev ||
                              ((ev || !ECHO) && echo_data !== ed)) begin
                    errors++; $display("FAIL rand[%0d.%0d] byte %0d got len=%0d ovf=%b echo=%b/%0d want %0d/%b/%b/%0d",
                                       line, k, b, line_len, overflow, echo_valid, echo_data,
                                       line_q.size(), m_ovf, ev, ed);
                end
            end
            b = ($urandom_range(0, 1) != 0) ? 8'd10 : 8'd13;
            model_step(b, ev, ed);
            drive_byte(b);
            end_drive();
            checks++; if (line_ready !== 1'b1 || rx_ready !== 1'b0 || echo_valid !== ev) begin
                errors++; $display("FAIL rand_term[%0d] got ready=%b rx_ready=%b echo=%b want 1/0/%b",
                                   line, line_ready, rx_ready, echo_valid, ev);
            end
            for (int i = 0; i < DEPTH; i++) begin
                rd_addr = ADDR_W'(i);
                @(negedge clk);
                checks++; if (rd_data !== exp_mem(i)) begin
                    errors++; $display("FAIL rand_mem[%0d][%0d] got %0d want %0d", line, i, rd_data, exp_mem(i));
                end
            end
            @(posedge clk); #1;
            do_ack();
            wait_clear(n);
            checks++; if (n != DEPTH) begin errors++; $display("FAIL rand_clear got %0d want %0d", n, DEPTH); end
        end
    endtask

    task automatic test_rst_midline();
        string s = "cle";
        bit ev;
        logic [7:0] ed;
        int n;
        for (int i = 0; i < s.len(); i++) begin
            model_step(s[i], ev, ed);
            drive_byte(s[i]);
        end
        end_drive();
        rst = 1'b1;
        rd_addr = '0;
        @(posedge clk); #1;
        line_q.delete();
        m_ovf = 1'b0;
        checks++; if (line_ready !== 1'b0 || rx_ready !== 1'b0 || rd_data !== 8'd0 || line_len !== 6'd0) begin
            errors++; $display("FAIL rst_mid got ready=%b rx_ready=%b rd=%0d len=%0d want 0/0/0/0",
                               line_ready, rx_ready, rd_data, line_len);
        end
        rst = 1'b0;
        wait_clear(n);
        checks++; if (n != DEPTH) begin errors++; $display("FAIL rst_mid_clear got %0d want %0d", n, DEPTH); end
        for (int i = 0; i < DEPTH; i++) begin
            rd_addr = ADDR_W'(i);
            @(negedge clk);
            checks++; if (rd_data !== 8'd0) begin errors++; $display("FAIL rst_mid_mem[%0d] got %0d want 0", i, rd_data); end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_uname();
        test_echo_build();
        test_overflow();
        test_ignored();
        test_random();
        test_rst_midline();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
